decode_writeback: RTL
=====================

// Module: decode_writeback
// PURPOSE
//   SEQ Decode + Write-back stage for the Y86-64 core; sits directly downstream of Fetch.
//   Consumes icode/rA/rB from Fetch and supplies valA/valB to Execute.
//   Commits valE/valM from Execute/Memory into the 15-entry register file on the clock edge.
//   Holds the sticky processor status (stat) that freezes architectural state after halt or error.
// PARAMETERS
//   WIDTH      64     data width of registers, valA/valB/valE/valM
//   NREGS      15     architectural registers, ids 0..14; id 4'hF = RNONE
//   RSP_RESET  64'h0  reset value of %rsp (id 4); all other registers reset to 0
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   icode        in   4      from Fetch
//   rA           in   4      from Fetch
//   rB           in   4      from Fetch
//   instr_valid  in   1      from Fetch; 0 = illegal instruction
//   imem_error   in   1      from Fetch; instruction address out of range
//   hlt          in   1      from Fetch; halt instruction decoded
//   dmem_error   in   1      from Memory; data address out of range
//   cnd          in   1      from Execute; condition result for cmovXX
//   valE         in   WIDTH  ALU result to commit
//   valM         in   WIDTH  memory read data to commit
//   valA         out  WIDTH  reg[srcA], or 0 if srcA==RNONE
//   valB         out  WIDTH  reg[srcB], or 0 if srcB==RNONE
//   dstE         out  4      E-port destination (for debug/trace)
//   dstM         out  4      M-port destination (for debug/trace)
//   stat         out  2      0=AOK 1=HLT 2=ADR 3=INS
// BEHAVIOUR
//   Decode (combinational, from current register contents; SEQ semantics):
//   - srcA: icode 2,4,6,A -> rA; 9,B -> 4; otherwise F.
//   - srcB: icode 4,5,6 -> rB; 8,9,A,B -> 4; otherwise F.
//   - dstE: icode 2 -> (cnd ? rB : F); 3,6 -> rB; 8,9,A,B -> 4; otherwise F.
//   - dstM: icode 5,B -> rA; otherwise F.
//   - A same-cycle write is not visible on valA/valB until after the clock edge (no bypass).
//   Write-back (at posedge clk):
//   - we = (stat==AOK) && !fault, where fault = imem_error|dmem_error|!instr_valid|hlt.
//   - If we and dstE!=F: reg[dstE] <= valE.
//   - If we and dstM!=F: reg[dstM] <= valM.
//   - If dstE==dstM!=F (popq %rsp): valM wins.
//   - Writes to RNONE are dropped; regs are full WIDTH, no truncation.
//   Status FSM (stat, sticky):
//   - AOK -> ADR if imem_error|dmem_error; else -> INS if !instr_valid; else -> HLT if hlt; else stay.
//   - Priority: ADR > INS > HLT.
//   - HLT/ADR/INS are absorbing until rst; no register writes occur while stat!=AOK.
//   - The faulting instruction itself does not commit.
//   Reset:
//   - rst=1 at posedge: all regs=0 except reg[4]=RSP_RESET; stat=AOK.
//   - Reset overrides any same-edge write; valid mid-program, leaves no partial commit.
//   - valA/valB/dstE/dstM follow the decode rules from reset contents.
// STRUCTURE
//   Shared package/header y86_defs.vh (shared with Fetch/Execute):
//   - icode constants (IHALT..IPOPQ).
//   - RRSP=4'h4, RNONE=4'hF.
//   - STAT_AOK/HLT/ADR/INS.
//   Sub-module regfile_2r2w (NREGS x WIDTH):
//   - 2 combinational read ports, 2 synchronous write ports, M-port priority, sync reset.
//   Decode muxes and status FSM live in decode_writeback.
// TESTING
//   1. rst 1 cycle -> all regs 0, reg[4]=RSP_RESET, stat=0; valA=valB=0 with icode=1.
//   2. irmovq: icode=3, rB=2, valE=64'h1234 -> next cycle icode=6, rA=2, rB=2 gives valA=valB=64'h1234.
//   3. cmovXX: icode=2, rA=1, rB=3, cnd=0, valE=5 -> reg[3] unchanged; cnd=1 -> reg[3]=5.
//   4. popq %rsp: icode=B, rA=4, valE=64'h100, valM=64'hBEEF -> reg[4]=64'hBEEF.
//   5. Fault path: dmem_error=1 with icode=5, rA=1 -> stat=2, reg[1] unchanged.
//      Later irmovq is ignored; stat stays 2 until rst, then stat=0.
//   6. Mid-program: rst asserted on the same edge as icode=3, rB=0, valE=7 -> reg[0]=0.
//      hlt=1 -> stat=1, no further writes.

Source files
------------

// File: rtl/decode_writeback_pkg.sv
// Shared Y86-64 definitions for the decode/write-back stage: icodes, register ids,
// status codes and the decode result payload.
package decode_writeback_pkg;

    localparam int unsigned WIDTH_DEF  = 64;
    localparam int unsigned NREGS_DEF  = 15;
    localparam int unsigned REG_ID_W   = 4;
    localparam logic [63:0] RSP_RESET_DEF = 64'h0;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef struct packed {
        logic [REG_ID_W-1:0] src_a;
        logic [REG_ID_W-1:0] src_b;
        logic [REG_ID_W-1:0] dst_e;
        logic [REG_ID_W-1:0] dst_m;
    } decode_t;

    // SEQ register-id selection for both read and both write ports.
    function automatic decode_t decode_ids(input logic [3:0] icode, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic cnd);
        decode_t d;
        d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
        case (icode)
            IRRMOVQ: begin d.src_a = ra; d.dst_e = cnd ? rb : RNONE; end
            IIRMOVQ: d.dst_e = rb;
            IRMMOVQ: begin d.src_a = ra; d.src_b = rb; end
            IMRMOVQ: begin d.src_b = rb; d.dst_m = ra; end
            IOPQ:    begin d.src_a = ra; d.src_b = rb; d.dst_e = rb; end
            ICALL:   begin d.src_b = RRSP; d.dst_e = RRSP; end
            IRET:    begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; end
            IPUSHQ:  begin d.src_a = ra; d.src_b = RRSP; d.dst_e = RRSP; end
            IPOPQ:   begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; d.dst_m = ra; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_writeback_regfile.sv
// Y86-64 register file: two combinational read ports, two synchronous write ports
// (M port wins on a shared destination), synchronous reset.
module decode_writeback_regfile
    import decode_writeback_pkg::*;
#(
    parameter int unsigned       WIDTH     = WIDTH_DEF,
    parameter int unsigned       NREGS     = NREGS_DEF,
    parameter logic [WIDTH-1:0]  RSP_RESET = WIDTH'(RSP_RESET_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              we,
    input  logic [3:0]        waddr_e,
    input  logic [WIDTH-1:0]  wdata_e,
    input  logic [3:0]        waddr_m,
    input  logic [WIDTH-1:0]  wdata_m
);

    logic [WIDTH-1:0] mem [NREGS];
    logic             wr_e;
    logic             wr_m;

    // Ids outside the array (RNONE) read as zero and never write.
    assign rdata_a = (32'(raddr_a) < NREGS) ? mem[raddr_a] : '0;
    assign rdata_b = (32'(raddr_b) < NREGS) ? mem[raddr_b] : '0;
    assign wr_e    = we && (waddr_e != RNONE) && (32'(waddr_e) < NREGS);
    assign wr_m    = we && (waddr_m != RNONE) && (32'(waddr_m) < NREGS);

    // The M write is issued last so it overrides E on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= (i == 32'(RRSP)) ? RSP_RESET : '0;
            end
        end else begin
            if (wr_e) mem[waddr_e] <= wdata_e;
            if (wr_m) mem[waddr_m] <= wdata_m;
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode + write-back stage: register-id decode, register file reads/commits,
// and the sticky processor status that freezes state after halt or error.
module decode_writeback
    import decode_writeback_pkg::*;
#(
    parameter int unsigned       WIDTH     = WIDTH_DEF,
    parameter int unsigned       NREGS     = NREGS_DEF,
    parameter logic [WIDTH-1:0]  RSP_RESET = WIDTH'(RSP_RESET_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              hlt,
    input  logic              dmem_error,
    input  logic              cnd,
    input  logic [WIDTH-1:0]  valE,
    input  logic [WIDTH-1:0]  valM,
    output logic [WIDTH-1:0]  valA,
    output logic [WIDTH-1:0]  valB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [1:0]        stat
);

    decode_t ids;
    stat_t   stat_q;
    logic    fault;
    logic    we;

    assign ids   = decode_ids(icode, rA, rB, cnd);
    assign dstE  = ids.dst_e;
    assign dstM  = ids.dst_m;
    assign fault = imem_error | dmem_error | ~instr_valid | hlt;
    assign we    = (stat_q == STAT_AOK) && !fault;
    assign stat  = stat_q;

    decode_writeback_regfile #(
        .WIDTH     (WIDTH),
        .NREGS     (NREGS),
        .RSP_RESET (RSP_RESET)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ids.src_a),
        .raddr_b (ids.src_b),
        .rdata_a (valA),
        .rdata_b (valB),
        .we      (we),
        .waddr_e (ids.dst_e),
        .wdata_e (valE),
        .waddr_m (ids.dst_m),
        .wdata_m (valM)
    );

    // Status is absorbing once it leaves AOK; ADR outranks INS outranks HLT.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= STAT_AOK;
        end else if (stat_q == STAT_AOK) begin
            if (imem_error | dmem_error) stat_q <= STAT_ADR;
            else if (!instr_valid)       stat_q <= STAT_INS;
            else if (hlt)                stat_q <= STAT_HLT;
        end
    end

endmodule
